pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 The block SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before lock is trusted.
REQ-002 The block SHALL have parameter RST_HOLD_CYCLES, default 256: cycles all resets stay asserted after lock qualifies.
REQ-003 The block SHALL have parameter STAGE_GAP_CYCLES, default 16: spacing between successive stage-reset releases, minimum 1.
REQ-004 The block SHALL have parameter NUM_STAGES, default 3: number of staged reset outputs, 1..8.
REQ-005 The block SHALL have port clk, input, width 1: free-running 27 MHz board clock (the PLL reference, not clkout).
REQ-006 The block SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-007 The block SHALL have port lock, input, width NUM_STAGES-independent 1: PLL lock, asynchronous to clk.
REQ-008 The block SHALL have port rst_out, output, width NUM_STAGES: active-high per-stage resets; bit 0 is released first.
REQ-009 The block SHALL have port ready, output, width 1: high once all stages are released.
REQ-010 The block SHALL have port lock_loss_count, output, width 8: saturating count of qualified-lock losses.
REQ-011 The block SHALL have port state_o, output, width 3: current FSM state encoding, for debug.

Function
REQ-012 lock SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value lock_s only.
REQ-013 The FSM SHALL have states WAIT_LOCK, STABILIZE, HOLD, RELEASE, RUN.
REQ-014 In WAIT_LOCK: lock_s=1 -> STABILIZE, counter cleared.
REQ-015 In STABILIZE: counter increments each cycle; lock_s=0 -> WAIT_LOCK, counter cleared, no loss counted; counter = LOCK_STABLE_CYCLES-1 -> HOLD, counter cleared.
REQ-016 In HOLD: counter = RST_HOLD_CYCLES-1 -> RELEASE; on that transition edge rst_out[0] deasserts.
REQ-017 In RELEASE: every STAGE_GAP_CYCLES cycles the next rst_out bit deasserts in index order; after rst_out[NUM_STAGES-1] deasserts, next cycle -> RUN and ready=1.
REQ-018 Timing, with edge 0 = first clk edge sampling lock=1 and lock held high: rst_out[0] falls at edge N = 2+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES; rst_out[k] at N+k*STAGE_GAP_CYCLES; ready rises at N+(NUM_STAGES-1)*STAGE_GAP_CYCLES+1.
REQ-019 lock_s=0 in HOLD, RELEASE or RUN SHALL, on the next edge, assert all rst_out bits, drop ready, increment lock_loss_count (saturating at 255), clear counter, and go to WAIT_LOCK.
REQ-020 A deasserted rst_out bit SHALL never reassert except via REQ-019 or rst; released bits stay released in order (thermometer pattern only).
REQ-021 NUM_STAGES=1 SHALL go HOLD -> RELEASE -> RUN with ready one cycle after rst_out[0] falls.
REQ-022 Counter width SHALL be clog2 of the largest of the three cycle parameters plus 1; no wrap-around occurs.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 rst=1 SHALL force WAIT_LOCK, counter=0, synchronizer flops=0, rst_out=all ones, ready=0, lock_loss_count=0, state_o=WAIT_LOCK encoding, on the next edge.
REQ-025 rst asserted mid-sequence (any state) SHALL override REQ-014..019 and not increment lock_loss_count.

Structure
REQ-026 The FSM state enum, its 3-bit encodings and the counter-width function SHALL live in the shared spectrometer package.
REQ-027 The synchronizer SHALL be a sub-module sync_2ff (1-bit, reset value 0), reusable elsewhere.

Verification (LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, STAGE_GAP_CYCLES=2, NUM_STAGES=3)
REQ-028 Clean lock: lock rises at edge 0, stays high -> rst_out 111 until edge 14, 110 at 14, 100 at 16, 000 at 18, ready=1 at 19, lock_loss_count=0.
REQ-029 Glitch in STABILIZE: lock high 5 cycles, low 3, high again -> back to WAIT_LOCK, rst_out stays 111, count stays 0; full sequence restarts from the second rise.
REQ-030 Loss in RUN: after ready, drop lock -> 3 edges later rst_out=111, ready=0, lock_loss_count=1, state WAIT_LOCK.
REQ-031 Loss in RELEASE: drop lock when rst_out=110 -> rst_out=111, count increments, bit 0 does not re-release until a full re-qualification.
REQ-032 Saturation: 260 qualified-lock losses -> lock_loss_count holds 255.
REQ-033 Reset mid-HOLD: assert rst for 1 cycle -> rst_out=111, ready=0, count=0, WAIT_LOCK; with lock still high, resequencing completes at the REQ-018 timing measured from rst release.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer_pkg
// Description : Shared FSM state encodings and counter sizing helper for the
//               PLL-lock-driven reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABILIZE = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } pll_state_t;

    // One spare bit above the largest terminal count so the counter never wraps.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop single-bit synchronizer, synchronous reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Qualifies PLL lock, holds resets, then releases staged resets
//               in index order; any lock loss after qualification restarts.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 256,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int NUM_STAGES         = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lock,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [7:0]            lock_loss_count,
    output logic [2:0]            state_o
);

    localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES, STAGE_GAP_CYCLES);

    localparam logic [CNT_W-1:0] c_stab_last = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    logic                  w_lock_s;

    pll_state_t            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_STAGES-1:0] r_rst_out;
    logic                  r_ready;
    logic [7:0]            r_loss_cnt;

    pll_state_t            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [NUM_STAGES-1:0] w_rst_out_nxt;
    logic                  w_ready_nxt;
    logic [7:0]            w_loss_nxt;
    logic                  w_qualified;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (lock),
        .o_q (w_lock_s)
    );

    assign w_qualified = (r_state == ST_HOLD) || (r_state == ST_RELEASE) || (r_state == ST_RUN);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rst_out_nxt = r_rst_out;
        w_ready_nxt   = r_ready;
        w_loss_nxt    = r_loss_cnt;

        if (w_qualified && !w_lock_s) begin
            w_state_nxt   = ST_WAIT_LOCK;
            w_cnt_nxt     = '0;
            w_rst_out_nxt = '1;
            w_ready_nxt   = 1'b0;
            if (r_loss_cnt != 8'hFF) begin
                w_loss_nxt = r_loss_cnt + 8'd1;
            end
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_nxt = ST_STABILIZE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_STABILIZE: begin
                    if (!w_lock_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_stab_last) begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == c_hold_last) begin
                        w_state_nxt   = ST_RELEASE;
                        w_cnt_nxt     = '0;
                        w_rst_out_nxt = r_rst_out << 1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                ST_RELEASE: begin
                    // Left shift keeps the released bits a contiguous run from bit 0.
                    if (r_rst_out == '0) begin
                        w_state_nxt = ST_RUN;
                        w_ready_nxt = 1'b1;
                    end else if (r_cnt == c_gap_last) begin
                        w_cnt_nxt     = '0;
                        w_rst_out_nxt = r_rst_out << 1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                ST_RUN: begin
                    w_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt   = ST_WAIT_LOCK;
                    w_cnt_nxt     = '0;
                    w_rst_out_nxt = '1;
                    w_ready_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_WAIT_LOCK;
            r_cnt      <= '0;
            r_rst_out  <= '1;
            r_ready    <= 1'b0;
            r_loss_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rst_out  <= w_rst_out_nxt;
            r_ready    <= w_ready_nxt;
            r_loss_cnt <= w_loss_nxt;
        end
    end

    assign rst_out         = r_rst_out;
    assign ready           = r_ready;
    assign lock_loss_count = r_loss_cnt;
    assign state_o         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Directed plus randomized bench for pll_reset_sequencer against
//               a run-length behavioural model of the lock qualification rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;
    import pll_reset_sequencer_pkg::*;

    localparam int L = 8;
    localparam int H = 4;
    localparam int G = 2;
    localparam int S = 3;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         lock = 1'b0;
    logic [S-1:0] rst_out;
    logic         ready;
    logic [7:0]   lock_loss_count;
    logic [2:0]   state_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES (L),
        .RST_HOLD_CYCLES    (H),
        .STAGE_GAP_CYCLES   (G),
        .NUM_STAGES         (S)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .lock            (lock),
        .rst_out         (rst_out),
        .ready           (ready),
        .lock_loss_count (lock_loss_count),
        .state_o         (state_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_run counts consecutive edges that saw synchronized lock high.
    int m_run  = 0;
    int m_loss = 0;
    bit m_s1   = 1'b0;
    bit m_s2   = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_run  = 0;
            m_loss = 0;
            m_s1   = 1'b0;
            m_s2   = 1'b0;
        end else begin
            if (m_s2) begin
                m_run++;
            end else begin
                if (m_run >= L + 1 && m_loss < 255) m_loss++;
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = lock;
        end
    end

    function automatic void model_out(input int r, output logic [S-1:0] e_rst,
                                      output logic e_rdy, output logic [2:0] e_st);
        int q;
        int rel;
        q   = L + H + 1;
        rel = 0;
        if (r >= q) rel = 1 + (r - q) / G;
        if (rel > S) rel = S;
        e_rst = '1;
        for (int i = 0; i < rel; i++) e_rst[i] = 1'b0;
        e_rdy = (r >= q + (S - 1) * G + 1);
        if (r == 0)          e_st = ST_WAIT_LOCK;
        else if (r <= L)     e_st = ST_STABILIZE;
        else if (r <= L + H) e_st = ST_HOLD;
        else if (e_rdy)      e_st = ST_RUN;
        else                 e_st = ST_RELEASE;
    endfunction

    logic [S-1:0] e_rst;
    logic         e_rdy;
    logic [2:0]   e_st;

    always @(negedge clk) begin
        if (cmp_en) begin
            model_out(m_run, e_rst, e_rdy, e_st);
            chk("model_rst_out", rst_out, e_rst);
            chk("model_ready", ready, e_rdy);
            chk("model_loss_count", lock_loss_count, m_loss);
            chk("model_state", state_o, e_st);
        end
    end

    // Next posedge must be edge 0 (first edge sampling lock=1) when called.
    task automatic check_seq(input int exp_cnt);
        int exp;
        for (int e = 0; e <= 20; e++) begin
            @(posedge clk);
            #1;
            exp = (e < 14) ? 7 : (e < 16) ? 6 : (e < 18) ? 4 : 0;
            chk("seq_rst_out", rst_out, exp);
            chk("seq_ready", ready, (e >= 19) ? 1 : 0);
            chk("seq_loss_count", lock_loss_count, exp_cnt);
        end
    endtask

    initial begin
        int k;
        rst  = 1'b1;
        lock = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_rst_out", rst_out, 7);
        chk("reset_ready", ready, 0);
        chk("reset_loss_count", lock_loss_count, 0);
        chk("reset_state", state_o, ST_WAIT_LOCK);

        // Clean lock
        rst  = 1'b0;
        lock = 1'b1;
        check_seq(0);

        // Loss in RUN
        @(negedge clk);
        lock = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("run_loss_rst_out", rst_out, 7);
        chk("run_loss_ready", ready, 0);
        chk("run_loss_count", lock_loss_count, 1);
        chk("run_loss_state", state_o, ST_WAIT_LOCK);

        // Glitch during STABILIZE
        @(negedge clk);
        lock = 1'b1;
        repeat (5) @(negedge clk);
        lock = 1'b0;
        repeat (3) @(negedge clk);
        chk("glitch_rst_out", rst_out, 7);
        chk("glitch_count", lock_loss_count, 1);
        chk("glitch_state", state_o, ST_WAIT_LOCK);
        lock = 1'b1;
        check_seq(1);

        // Loss around first release
        @(negedge clk);
        lock = 1'b0;
        repeat (4) @(negedge clk);
        chk("requal_count", lock_loss_count, 2);
        lock = 1'b1;
        repeat (14) @(posedge clk);
        @(negedge clk);
        lock = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rel_loss_rst_out", rst_out, 7);
        chk("rel_loss_count", lock_loss_count, 3);
        chk("rel_loss_state", state_o, ST_WAIT_LOCK);
        @(negedge clk);
        lock = 1'b1;
        check_seq(3);

        // Saturation
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            lock = 1'b1;
            repeat (12) @(negedge clk);
            lock = 1'b0;
            repeat (3) @(negedge clk);
        end
        chk("sat_count", lock_loss_count, 255);

        // Reset mid-HOLD
        @(negedge clk);
        lock = 1'b1;
        k = 0;
        while (state_o != ST_HOLD && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("hold_reached", (state_o == ST_HOLD) ? 1 : 0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_rst_out", rst_out, 7);
        chk("midrst_ready", ready, 0);
        chk("midrst_count", lock_loss_count, 0);
        chk("midrst_state", state_o, ST_WAIT_LOCK);
        check_seq(0);

        // Randomized lock activity with occasional resets
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1'b0;
            end
            lock = ~lock;
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
